// File: rtl/uart_rx_bit_timer.sv
// uart_rx_bit_timer: UART receive bit-timing engine (sync, start detect, mid-bit strobes, parity/framing check)
//   clk, rst_n        : clock, asynchronous active-low reset
//   en                : receiver enable, low forces IDLE and suppresses pulses
//   rx                : raw asynchronous serial input, idle high
//   busy              : state != IDLE
//   sample_stb        : one-cycle mid-bit strobe for every data/parity/stop bit
//   sample_bit        : synchronised rx captured with sample_stb
//   bit_idx           : index of the sampled bit (data, then parity, then stop bits)
//   start_err         : start bit found high at its mid-point
//   frame_done        : pulse with the final stop-bit strobe
//   frame_err         : with frame_done, some stop bit sampled 0
//   parity_err        : with frame_done, parity mismatch
module uart_rx_bit_timer #(
  parameter int BIT_DIV     = 5208,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx,
  output logic       busy,
  output logic       sample_stb,
  output logic       sample_bit,
  output logic [3:0] bit_idx,
  output logic       start_err,
  output logic       frame_done,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int CW        = $clog2(BIT_DIV);
  localparam int HALF      = BIT_DIV / 2;
  localparam int LAST_BIT  = (PARITY_MODE != 0) ? DATA_BITS : DATA_BITS - 1;
  localparam int LAST_STOP = LAST_BIT + STOP_BITS;
  typedef enum logic [1:0] {IDLE, START, BITS, STOP} state_e;
  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic                   par_q, par_d;
  logic                   ferr_q, ferr_d;
  logic                   sample_stb_q, sample_stb_d;
  logic                   sample_bit_q, sample_bit_d;
  logic [3:0]             bit_idx_q, bit_idx_d;
  logic                   start_err_q, start_err_d;
  logic                   frame_done_q, frame_done_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   rx_s, fall, mid, wrap, last, stb;
  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = prev_q & ~rx_s;
  assign mid  = cnt_q == CW'(HALF);
  assign wrap = cnt_q == CW'(BIT_DIV - 1);
  assign last = state_q == STOP && mid && idx_q == 4'(LAST_STOP);
  assign stb  = en && (state_q == BITS || state_q == STOP) && mid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    if (!en) state_d = IDLE;
    else begin
      case (state_q)
        IDLE:    state_d = fall ? START : IDLE;
        START:   state_d = (mid && rx_s) ? IDLE : wrap ? BITS : START;
        BITS:    state_d = (wrap && idx_q == 4'(LAST_BIT)) ? STOP : BITS;
        default: state_d = last ? IDLE : STOP;
      endcase
    end
  end
  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], rx};
    // hold the edge-delay flop while leaving STOP so an edge in that cycle is still seen in IDLE
    prev_d       = last ? prev_q : rx_s;
    // the edge-detect cycle already belongs to the start bit, so counting resumes at 1
    cnt_d        = (state_d == IDLE) ? '0 : (state_q == IDLE) ? CW'(1) : wrap ? '0 : cnt_q + 1'b1;
    idx_d        = (state_q == BITS || state_q == STOP) ? (wrap ? idx_q + 4'd1 : idx_q) : 4'd0;
    par_d        = (state_q == START) ? 1'b0 : (state_q == BITS && mid) ? par_q ^ rx_s : par_q;
    ferr_d       = (state_q == START) ? 1'b0 : (state_q == STOP && mid) ? ferr_q | ~rx_s : ferr_q;
    sample_stb_d = stb;
    sample_bit_d = stb ? rx_s : sample_bit_q;
    bit_idx_d    = stb ? idx_q : bit_idx_q;
    start_err_d  = en && state_q == START && mid && rx_s;
    frame_done_d = en && last;
    frame_err_d  = en && last && (ferr_q | ~rx_s);
    parity_err_d = en && last && (PARITY_MODE == 1 ? ~par_q : PARITY_MODE == 2 ? par_q : 1'b0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= '1;
      prev_q       <= 1'b1;
      cnt_q        <= '0;
      idx_q        <= 4'd0;
      par_q        <= 1'b0;
      ferr_q       <= 1'b0;
      sample_stb_q <= 1'b0;
      sample_bit_q <= 1'b1;
      bit_idx_q    <= 4'd0;
      start_err_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      par_q        <= par_d;
      ferr_q       <= ferr_d;
      sample_stb_q <= sample_stb_d;
      sample_bit_q <= sample_bit_d;
      bit_idx_q    <= bit_idx_d;
      start_err_q  <= start_err_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end
  assign busy       = state_q != IDLE;
  assign sample_stb = sample_stb_q;
  assign sample_bit = sample_bit_q;
  assign bit_idx    = bit_idx_q;
  assign start_err  = start_err_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
endmodule

// File: tb/tb_uart_rx_bit_timer.sv
// tb_uart_rx_bit_timer: scoreboard bench for 8N1, 8E1 and 8N2 receivers at BIT_DIV=16
module tb_uart_rx_bit_timer;
  logic       clk, rst_n, en;
  logic [2:0] rx_v, busy_v, stb_v, sbit_v, serr_v, done_v, ferr_v, perr_v;
  logic [3:0] bidx_v [3];
  int         cyc, n_tests, n_fail;
  int         exp_ev[$], exp_t[$];
  for (genvar g = 0; g < 3; g++) begin : dut
    uart_rx_bit_timer #(
      .BIT_DIV(16), .DATA_BITS(8), .PARITY_MODE(g == 1 ? 2 : 0),
      .STOP_BITS(g == 2 ? 2 : 1), .SYNC_STAGES(2)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .rx(rx_v[g]), .busy(busy_v[g]),
      .sample_stb(stb_v[g]), .sample_bit(sbit_v[g]), .bit_idx(bidx_v[g]),
      .start_err(serr_v[g]), .frame_done(done_v[g]), .frame_err(ferr_v[g]),
      .parity_err(perr_v[g])
    );
  end
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask
  task automatic pop(input int ev);
    int e = -1, t = -1;
    if (exp_ev.size() != 0) begin
      e = exp_ev.pop_front();
      t = exp_t.pop_front();
    end
    check("event", ev, e);
    check("event_cycle", cyc, t);
  endtask
  for (genvar g = 0; g < 3; g++) begin : mon
    always @(negedge clk) begin
      if (stb_v[g]) pop((g << 12) | (1 << 8) | (int'(bidx_v[g]) << 4) | (int'(sbit_v[g]) << 2));
      if (done_v[g]) pop((g << 12) | (2 << 8) | (int'(ferr_v[g]) << 1) | int'(perr_v[g]));
      if (serr_v[g]) pop((g << 12) | (3 << 8));
    end
  end
  // called at a negedge; pb < 0 means no parity bit; ab >= 0 aborts 5 cycles into data bit ab
  task automatic send(input int g, input logic [7:0] d, input int pb, input logic [1:0] st, input int ab);
    int p0 = cyc + 1;
    int n = 9;
    int ns = (g == 2) ? 2 : 1;
    logic [12:0] v = '0;
    logic fe, pe;
    for (int i = 0; i < 8; i++) v[1 + i] = d[i];
    if (pb >= 0) begin
      v[n] = pb[0];
      n++;
    end
    for (int s = 0; s < ns; s++) begin
      v[n] = st[s];
      n++;
    end
    fe = (ns == 2) ? ~(st[0] & st[1]) : ~st[0];
    pe = (g == 1) ? (^d ^ pb[0]) : 1'b0;
    for (int k = 1; k < n; k++) begin
      if (ab < 0 || k - 1 < ab) begin
        exp_ev.push_back((g << 12) | (1 << 8) | ((k - 1) << 4) | (int'(v[k]) << 2));
        exp_t.push_back(p0 + 26 + 16 * (k - 1));
        if (k == n - 1) begin
          exp_ev.push_back((g << 12) | (2 << 8) | (int'(fe) << 1) | int'(pe));
          exp_t.push_back(p0 + 26 + 16 * (k - 1));
        end
      end
    end
    for (int k = 0; k < n; k++) begin
      rx_v[g] = v[k];
      if (ab >= 0 && k == ab + 1) begin
        repeat (5) @(negedge clk);
        return;
      end
      repeat (16) @(negedge clk);
    end
    rx_v[g] = 1'b1;
  endtask
  initial begin
    cyc = 0; n_tests = 0; n_fail = 0;
    rst_n = 1'b0; en = 1'b1; rx_v = 3'b111;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      check("rst_busy", busy_v[g], 0);
      check("rst_stb", stb_v[g], 0);
      check("rst_sample_bit", sbit_v[g], 1);
      check("rst_bit_idx", bidx_v[g], 0);
      check("rst_flags", {serr_v[g], done_v[g], ferr_v[g], perr_v[g]}, 0);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send(0, 8'hA5, -1, 2'b11, -1);
    repeat (4) @(negedge clk);
    exp_ev.push_back(3 << 8);
    exp_t.push_back(cyc + 11);
    rx_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (30) @(negedge clk);
    check("glitch_busy", busy_v[0], 0);
    send(1, 8'h07, 0, 2'b11, -1);
    send(1, 8'h07, 1, 2'b11, -1);
    send(2, 8'h3C, -1, 2'b10, -1);
    send(2, 8'h81, -1, 2'b11, -1);
    send(0, 8'h3C, -1, 2'b11, -1);
    send(0, 8'hE1, -1, 2'b11, -1);
    repeat (4) @(negedge clk);
    en = 1'b0;
    rx_v[0] = 1'b0;
    repeat (20) @(negedge clk);
    rx_v[0] = 1'b1;
    repeat (10) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    check("en_low_edge_busy", busy_v[0], 0);
    send(0, 8'h5A, -1, 2'b11, 3);
    check("pre_en_drop_busy", busy_v[0], 1);
    en = 1'b0;
    @(negedge clk);
    check("en_drop_busy", busy_v[0], 0);
    rx_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    send(0, 8'h96, -1, 2'b11, -1);
    send(0, 8'hC3, -1, 2'b11, 3);
    check("pre_rst_busy", busy_v[0], 1);
    check("pre_rst_sample_bit", sbit_v[0], 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy_v[0], 0);
    check("async_rst_sample_bit", sbit_v[0], 1);
    check("async_rst_bit_idx", bidx_v[0], 0);
    rx_v[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 8'h6B, -1, 2'b11, -1);
    for (int i = 0; i < 300 && exp_ev.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_ev.size(), 0);
    check("final_busy", busy_v, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
